// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: state encoding and default geometry shared by the loader,
// the CPU and the instruction SRAM instances.
package prog_loader_pkg;

  // Default instruction-memory geometry (16 x 8 SRAM, full image).
  localparam int PL_ADDR   = 4;
  localparam int PL_WIDTH  = 8;
  localparam int PL_LENGTH = 16;

  // Loader state encoding.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_LAST  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_LAST  = ST_LAST,
    S_CHECK = ST_CHECK,
    S_DONE  = ST_DONE,
    S_ERROR = ST_ERROR
  } pl_state_e;

endpackage

// File: rtl/prog_loader.sv
// prog_loader: streams bytes from a valid/ready source into the instruction
// SRAM at addresses 0..LENGTH-1 and holds the CPU in reset until the image is
// complete. Define PROG_LOADER_CHECKSUM_EN to require a trailing 8-bit
// modular-sum checksum byte; a mismatch parks the loader in ERROR with the
// CPU still in reset.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR   = PL_ADDR,
  parameter int WIDTH  = PL_WIDTH,
  parameter int LENGTH = PL_LENGTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             mem_cs,
  output logic             mem_we,
  output logic [ADDR-1:0]  mem_addr,
  output logic [WIDTH-1:0] mem_data,
  output logic             cpu_reset,
  output logic             busy,
  output logic             done,
  output logic             error
);

  // Counter value of the final data word; the counter stops here, no wrap.
  localparam logic [ADDR-1:0] LAST_CNT = ADDR'(LENGTH - 1);

  pl_state_e        state_q;
  logic [ADDR-1:0]  cnt_q;
  logic             in_ready_q;
  logic             mem_cs_q;
  logic             mem_we_q;
  logic [ADDR-1:0]  mem_addr_q;
  logic [WIDTH-1:0] mem_data_q;
  logic             cpu_reset_q;
  logic             busy_q;
  logic             done_q;
  logic             accept;

  // in_ready_q is only high in LOAD/CHECK, so this is the full handshake.
  assign accept = in_valid && in_ready_q;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] sum_q;
  logic             error_q;

  // Running modular sum of the data bytes of the current image.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else if ((state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR) && start) begin
      sum_q <= '0;
    end else if (state_q == S_LOAD && accept) begin
      sum_q <= sum_q + in_data;
    end
  end
`endif

  // Loader FSM; all outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      error_q     <= 1'b0;
`endif
    end else begin
      // Write strobe lasts exactly one cycle per accepted byte.
      mem_cs_q <= 1'b0;
      mem_we_q <= 1'b0;
      case (state_q)
`ifdef PROG_LOADER_CHECKSUM_EN
        S_IDLE, S_DONE, S_ERROR: begin
`else
        S_IDLE, S_DONE: begin
`endif
          if (start) begin
            state_q     <= S_LOAD;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            error_q     <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (accept) begin
            mem_cs_q   <= 1'b1;
            mem_we_q   <= 1'b1;
            mem_addr_q <= cnt_q;
            mem_data_q <= in_data;
            if (cnt_q == LAST_CNT) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              // Stay ready: the next byte is the checksum.
              state_q    <= S_CHECK;
`else
              state_q    <= S_LAST;
              in_ready_q <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_LAST: begin
          // Final strobe is on the bus this cycle; release the CPU next.
          state_q     <= S_DONE;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          cpu_reset_q <= 1'b0;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHECK: begin
          // Checksum byte is compared, never written to memory.
          if (accept) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (in_data == sum_q) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b0;
          cpu_reset_q <= 1'b1;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
          error_q     <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign error     = error_q;
`else
  assign error     = 1'b0;
`endif

endmodule

// File: doc/prog_loader.md
# prog_loader

Instruction-memory loader: accepts a byte stream over a valid/ready handshake and writes it sequentially into the CPU's 16×8 instruction SRAM. It is the writing side of the instruction-fetch path, filling memory at addresses 0..LENGTH-1. It holds the CPU in reset until a complete image has been written. It sits between the host/debug byte source and the SRAM write port, and drives the CPU reset.

## Interface
- ADDR, 4: SRAM address width.
- WIDTH, 8: data/instruction width.
- LENGTH, 16: number of words per image; must be ≤ 2^ADDR.
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR.
- in_valid  input  1  source byte valid.
- in_data  input  WIDTH  source byte.
- in_ready  output  1  loader accepts byte this cycle.
- mem_cs  output  1  SRAM chip select (registered).
- mem_we  output  1  SRAM write enable (registered).
- mem_addr  output  ADDR  SRAM write address (registered).
- mem_data  output  WIDTH  SRAM write data (registered).
- cpu_reset  output  1  holds CPU in reset while high.
- busy  output  1  high in LOAD, LAST, CHECK.
- done  output  1  image loaded; high in DONE.
- error  output  1  checksum failure; high in ERROR.

## Operation
- States: IDLE, LOAD, LAST, CHECK, DONE, ERROR.
- IDLE: in_ready=0, cpu_reset=1. start → LOAD, word counter cnt=0, running sum=0.
- LOAD: in_ready=1. Accept when in_valid&&in_ready. On accept: register mem_cs=1, mem_we=1, mem_addr=cnt, mem_data=in_data; sum += in_data mod 2^WIDTH; cnt++. Accept with cnt==LENGTH-1 → LAST (macro off) or CHECK (macro on).
- LAST: in_ready=0; the final write strobe is active. Next state DONE.
- CHECK: in_ready=1; the final write strobe is active in the first CHECK cycle. The accepted byte is the checksum and is not written. Checksum == sum → DONE, else → ERROR.
- DONE: cpu_reset=0, done=1, in_ready=0. start → LOAD; cpu_reset re-asserts on the next cycle.
- ERROR: cpu_reset=1, error=1, in_ready=0. start → LOAD.
- start in LOAD/LAST/CHECK is ignored. in_valid outside LOAD/CHECK is ignored.
- mem_cs/mem_we are low in every cycle that does not follow an accept in LOAD.
- No address wrap: cnt never exceeds LENGTH-1. When LENGTH < 2^ADDR, upper addresses are never written.

## Timing
- Reset values: state=IDLE, in_ready=0, mem_cs=0, mem_we=0, mem_addr=0, mem_data=0, cpu_reset=1, busy=0, done=0, error=0, cnt=0, sum=0.
- Handshake: transfer on the rising edge where in_valid&&in_ready. Back-to-back transfers sustain 1 byte/cycle.
- Write latency: byte accepted at edge E appears on mem_* during cycle E..E+1. The strobe is exactly one cycle wide per byte.
- Macro off: last data accepted at edge E → LAST during E..E+1 → DONE at E+1. cpu_reset falls at E+1, done rises at E+1.
- Macro on: DONE/ERROR entered on the edge that accepts the checksum byte.
- Reset mid-load: return to IDLE on that edge. Write strobes drop immediately (registered). The SRAM holds a partial image. cpu_reset=1.
- reset has priority over start on the same edge.

## Configuration
- PROG_LOADER_CHECKSUM_EN defined: after LENGTH data bytes, one extra checksum byte (8-bit modular sum) is required. Mismatch → ERROR, and the CPU stays in reset.
- PROG_LOADER_CHECKSUM_EN undefined: the CHECK and ERROR states and the sum register are removed, error is tied to 0, and the path is LOAD → LAST → DONE.

## Structure
- Shared package: the state encoding localparams (IDLE..ERROR) and the default ADDR/WIDTH/LENGTH constants shared with the CPU and SRAM instances.
- Single module. No sub-module is needed; the checksum accumulator is inline and guarded by the macro.

## Test plan
- Basic load (macro off): start, stream 0x00..0x0F back-to-back → 16 write strobes with addr 0..15 and data 0..15 each one cycle after its accept; done=1 and cpu_reset=0 one cycle after the last strobe.
- Gapped source: in_valid toggles 1,0,0,1 … → the strobe count equals the accept count, addresses are contiguous, and no strobe occurs in gap cycles.
- Checksum pass (macro on): bytes 0x01×16, then checksum 0x10 → DONE, error=0, no write for the checksum byte.
- Checksum fail (macro on): same data, checksum 0x11 → ERROR, cpu_reset stays 1; a subsequent start reloads successfully.
- Reset mid-load: reset asserted after 5 accepts → next cycle IDLE, mem_we=0, cpu_reset=1, in_ready=0; a new start begins at addr 0.
- Reload from DONE, plus start during LOAD: start in DONE → cpu_reset=1 the next cycle and addr restarts at 0; a start pulse during LOAD leaves cnt unchanged.
